uart_tx_feeder: RTL and testbench

- Byte buffer and sequencer directly upstream of the UART transmitter.
- Accepts bytes from the system side into a synchronous FIFO, then sends them one at a time to the transmitter.
- Drives the transmitter's data_in/tx_start, holds data stable for the whole frame, and waits for its tx_done pulse before issuing the next byte.
- Lets producers burst up to DEPTH bytes without tracking UART timing.

---
 rtl/uart_tx_feeder.sv | 118 +++++++++++
 tb/tb_uart_tx_feeder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - byte FIFO and frame sequencer feeding a UART transmitter
module uart_tx_feeder #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        wr_data,
  input  logic              wr_en,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_done,
  output logic              busy
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_GAP} state_t;

  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  state_t            r_state;
  state_t            w_next_state;
  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_full;
  logic              r_empty;
  logic              r_overflow;
  logic [7:0]        r_tx_data;
  logic              r_tx_start;
  logic              r_busy;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W:0]   w_count_next;

  // The pop happens on the IDLE->LOAD edge, so it is keyed off the current state.
  assign w_push = wr_en && !r_full;
  assign w_pop  = (r_state == S_IDLE) && !r_empty;

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CNT_ONE;
      2'b01:   w_count_next = r_count - CNT_ONE;
      default: w_count_next = r_count;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (!r_empty) w_next_state = S_LOAD;
      S_LOAD:  w_next_state = S_START;
      S_START: w_next_state = S_WAIT;
      S_WAIT:  if (tx_done) w_next_state = S_GAP;
      S_GAP:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
      r_tx_data  <= 8'h00;
      r_tx_start <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + PTR_ONE;
        r_tx_data <= r_mem[r_rd_ptr];
      end
      r_count    <= w_count_next;
      r_full     <= (w_count_next == FULL_CNT);
      r_empty    <= (w_count_next == '0);
      // Full is judged before the edge, so a same-edge pop does not rescue the write.
      r_overflow <= wr_en && r_full;
      r_tx_start <= (w_next_state == S_START);
      r_busy     <= (w_next_state != S_IDLE);
    end
  end

  assign full     = r_full;
  assign empty    = r_empty;
  assign count    = r_count;
  assign overflow = r_overflow;
  assign tx_data  = r_tx_data;
  assign tx_start = r_tx_start;
  assign busy     = r_busy;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - randomized self-checking bench for uart_tx_feeder
module tb_uart_tx_feeder;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk     = 1'b0;
  logic              reset_n = 1'b1;
  logic [7:0]        wr_data = 8'h00;
  logic              wr_en   = 1'b0;
  logic              tx_done = 1'b0;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              tx_start;
  logic              busy;
  logic [ADDR_W:0]   count;
  logic [7:0]        tx_data;

  int tests = 0;
  int fails = 0;

  // Reference model: queue of stored bytes plus frame timeline in edge numbers.
  logic [7:0] q[$];
  logic [7:0] m_data     = 8'h00;
  bit         m_in_frame = 1'b0;
  bit         m_ovf      = 1'b0;
  int         edge_n     = 0;
  int         ready_edge = 0;
  int         pop_edge   = -10;
  int         done_edge  = -10;
  int         done_cnt   = 0;
  int         dly_min    = 2;
  int         dly_max    = 4;
  bit         stall      = 1'b0;
  bit         spur       = 1'b0;

  always #5 clk = ~clk;

  uart_tx_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_done  (tx_done),
    .busy     (busy)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  // One clock: apply inputs, advance the model across the edge, compare just after it.
  task automatic step(input logic we, input logic [7:0] wd);
    logic d;
    bit   pop;
    bit   dn;
    d = 1'b0;
    if (!stall && done_cnt > 0) begin
      done_cnt--;
      d = (done_cnt == 0);
    end else if (spur && !stall && done_cnt == 0 && $urandom_range(0, 9) == 0) begin
      d = 1'b1;
    end
    wr_en   = we;
    wr_data = wd;
    tx_done = d;
    @(posedge clk);
    edge_n++;
    m_ovf = we && (q.size() == DEPTH);
    pop   = !m_in_frame && edge_n >= ready_edge && q.size() > 0;
    dn    = m_in_frame && edge_n >= pop_edge + 3 && d;
    if (pop) begin
      m_data     = q.pop_front();
      m_in_frame = 1'b1;
      pop_edge   = edge_n;
    end
    if (we && !m_ovf) q.push_back(wd);
    if (dn) begin
      m_in_frame = 1'b0;
      done_edge  = edge_n;
      ready_edge = edge_n + 2;
    end
    #1;
    check_val("count", count, q.size());
    check_val("empty", empty, q.size() == 0);
    check_val("full", full, q.size() == DEPTH);
    check_val("overflow", overflow, m_ovf);
    check_val("tx_start", tx_start, edge_n == pop_edge + 1);
    check_val("busy", busy, m_in_frame || edge_n == done_edge);
    check_val("tx_data", tx_data, m_data);
    if (edge_n == pop_edge + 1) done_cnt = $urandom_range(dly_min, dly_max);
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while ((q.size() != 0 || m_in_frame || edge_n <= done_edge + 1) && n < bound) begin
      step(1'b0, 8'h00);
      n++;
    end
    check_val("drain_in_time", n < bound, 1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    wr_en   = 1'b0;
    tx_done = 1'b0;
    #1;
    check_val("rst_count", count, 0);
    check_val("rst_empty", empty, 1);
    check_val("rst_full", full, 0);
    check_val("rst_overflow", overflow, 0);
    check_val("rst_tx_start", tx_start, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_tx_data", tx_data, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    q.delete();
    m_data     = 8'h00;
    m_in_frame = 1'b0;
    m_ovf      = 1'b0;
    ready_edge = 0;
    pop_edge   = -10;
    done_edge  = -10;
    done_cnt   = 0;
    stall      = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit wrote;
    int acc;
    int n;
    logic we;

    #2;
    do_reset();
    repeat (100) step(1'b0, 8'h00);

    dly_min = 20; dly_max = 20;
    step(1'b1, 8'hA5);
    drain(200);

    for (int i = 1; i <= 5; i++) step(1'b1, 8'(i));
    drain(400);

    dly_min = 2; dly_max = 4;
    stall = 1'b1;
    for (int i = 0; i < 18; i++) step(1'b1, 8'(8'h80 + i));
    stall = 1'b0;
    drain(2000);

    // Write landing on the same edge as a pop with DEPTH-1 bytes stored.
    stall = 1'b1;
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h40 + i));
    stall = 1'b0;
    wrote = 1'b0;
    n = 0;
    while (!wrote && n < 300) begin
      if (!m_in_frame && edge_n + 1 == ready_edge) begin
        check_val("pre_coincide_count", count, DEPTH - 1);
        step(1'b1, 8'hC3);
        check_val("coincide_count", count, DEPTH - 1);
        wrote = 1'b1;
      end else begin
        step(1'b0, 8'h00);
      end
      n++;
    end
    check_val("coincide_reached", wrote, 1);
    drain(2000);

    dly_min = 2; dly_max = 6;
    acc = 0;
    n = 0;
    while (acc < 40 && n < 3000) begin
      we = ($urandom_range(0, 3) != 0);
      if (we && q.size() < DEPTH) acc++;
      step(we, 8'($urandom));
      n++;
    end
    check_val("wrap_writes", acc, 40);
    drain(2000);

    stall = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hE0 + i));
    repeat (5) step(1'b0, 8'h00);
    check_val("midframe_queued", count, 3);
    do_reset();
    repeat (100) step(1'b0, 8'h00);

    spur = 1'b1;
    dly_min = 2; dly_max = 30;
    for (int i = 0; i < 800; i++) step($urandom_range(0, 2) == 0, 8'($urandom));
    drain(3000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
